// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-read-port register file.
package regfile_pkg;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_READ      = 2;
  localparam int DEF_DEPTH         = 1 << DEF_ADDRESS_WIDTH;

  // x0 is hardwired to zero: never written, never pending.
  localparam int ZERO_REG = 0;

  typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0]    reg_data_t;

  function automatic logic addr_is_zero(input reg_addr_t addr);
    return addr == reg_addr_t'(ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, writeback clears, issue wins a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue,
  input  logic [ADDRESS_WIDTH-1:0]      issue_rd,
  input  logic                          we,
  input  logic [ADDRESS_WIDTH-1:0]      wa,
  output logic [(1<<ADDRESS_WIDTH)-1:0] pending
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(ZERO_REG);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] pending_nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue && (issue_rd != X0)) set_vec[issue_rd] = 1'b1;
    if (we && (wa != X0))          clr_vec[wa]       = 1'b1;
    // Set is applied after clear so a same-cycle issue survives its predecessor's writeback.
    pending_nxt           = (pending & ~clr_vec) | set_vec;
    pending_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads and hazard scoreboard.
// Build option: define REGFILE_BYPASS_EN for write-first reads on address collision.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_READ      = DEF_NUM_READ
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic                              iWE,
  input  logic [ADDRESS_WIDTH-1:0]          iWA,
  input  logic [DATA_WIDTH-1:0]             iWD,
  input  logic [NUM_READ-1:0]               iRE,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] iRA,
  output logic [NUM_READ*DATA_WIDTH-1:0]    oRD,
  output logic [NUM_READ-1:0]               oBUSY,
  input  logic                              iISSUE,
  input  logic [ADDRESS_WIDTH-1:0]          iISSUE_RD
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic                  wr_en;

  assign wr_en = iWE && (iWA != X0);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[iWA] <= iWD;
    end
  end

  regfile_scoreboard #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_scoreboard (
    .clk      (iCLK),
    .rst      (iRST),
    .issue    (iISSUE),
    .issue_rd (iISSUE_RD),
    .we       (iWE),
    .wa       (iWA),
    .pending  (pending)
  );

  for (genvar p = 0; p < NUM_READ; p++) begin : gen_read
    logic [ADDRESS_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0]    rd_val;
    logic                     busy_val;
    logic [DATA_WIDTH-1:0]    rd_p1;
    logic                     busy_p1;

    assign ra = iRA[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    // busy_val uses the registered pending state, so an issue never sees itself.
    always_comb begin
      rd_val   = (ra == X0) ? '0 : mem[ra];
      busy_val = pending[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (iWA == ra)) begin
        rd_val   = iWD;
        busy_val = 1'b0;
      end
`endif
    end

    // Read stage boundary: one-cycle registered output, held while the port is idle.
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        rd_p1   <= '0;
        busy_p1 <= 1'b0;
      end else if (iRE[p]) begin
        rd_p1   <= rd_val;
        busy_p1 <= busy_val;
      end
    end

    assign oRD[p*DATA_WIDTH +: DATA_WIDTH] = rd_p1;
    assign oBUSY[p]                        = busy_p1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (two read ports, default widths).
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

`ifdef REGFILE_BYPASS_EN
  localparam logic [DW-1:0] COL_RD   = 32'h22;
  localparam logic [NR-1:0] COL_BUSY = 2'b00;
`else
  localparam logic [DW-1:0] COL_RD   = 32'h11;
  localparam logic [NR-1:0] COL_BUSY = 2'b11;
`endif

  logic             iCLK;
  logic             iRST;
  logic             iWE;
  logic [AW-1:0]    iWA;
  logic [DW-1:0]    iWD;
  logic [NR-1:0]    iRE;
  logic [NR*AW-1:0] iRA;
  logic [NR*DW-1:0] oRD;
  logic [NR-1:0]    oBUSY;
  logic             iISSUE;
  logic [AW-1:0]    iISSUE_RD;

  int tests = 0;
  int fails = 0;

  regfile_mp #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .NUM_READ     (NR)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iWE       (iWE),
    .iWA       (iWA),
    .iWD       (iWD),
    .iRE       (iRE),
    .iRA       (iRA),
    .oRD       (oRD),
    .oBUSY     (oBUSY),
    .iISSUE    (iISSUE),
    .iISSUE_RD (iISSUE_RD)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    iWE = 1'b0; iWA = '0; iWD = '0;
    iRE = '0;
    iISSUE = 1'b0; iISSUE_RD = '0;
  endtask

  task automatic test_reset();
    tests++;
    if (oRD !== '0 || oBUSY !== '0) begin
      fails++; $display("FAIL reset_state rd=%h busy=%b exp 0/0", oRD, oBUSY);
    end
    // Load a value and a pending bit so reset has something to clear.
    iWE = 1; iWA = 5; iWD = 32'h55; iISSUE = 1; iISSUE_RD = 31;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd31, 5'd5};
    tick();
    tests++;
    if (oRD[31:0] !== 32'h55 || oBUSY !== 2'b10) begin
      fails++; $display("FAIL pre_reset rd0=%h busy=%b exp 00000055/10", oRD[31:0], oBUSY);
    end
    #2;
    iRST = 1; iWE = 1; iWA = 9; iWD = 32'h99; iISSUE = 1; iISSUE_RD = 9;
    #1;
    tests++;
    if (oRD !== '0 || oBUSY !== '0) begin
      fails++; $display("FAIL async_reset rd=%h busy=%b exp 0/0", oRD, oBUSY);
    end
    tick();
    iRST = 0;
    idle(); iRE = 2'b11; iRA = {5'd31, 5'd5};
    tick();
    tests++;
    if (oRD !== '0 || oBUSY !== '0) begin
      fails++; $display("FAIL post_reset_read rd=%h busy=%b exp 0/0", oRD, oBUSY);
    end
    iRA = {5'd9, 5'd9};
    tick();
    tests++;
    if (oRD !== '0 || oBUSY !== '0) begin
      fails++; $display("FAIL reset_discard_write rd=%h busy=%b exp 0/0", oRD, oBUSY);
    end
  endtask

  task automatic test_x0();
    idle(); iWE = 1; iWA = 1; iWD = 32'h1111; iISSUE = 1; iISSUE_RD = 2;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd2, 5'd1};
    tick();
    tests++;
    if (oRD[31:0] !== 32'h1111 || oBUSY !== 2'b10) begin
      fails++; $display("FAIL x0_setup rd0=%h busy=%b exp 00001111/10", oRD[31:0], oBUSY);
    end
    idle(); iWE = 1; iWA = 0; iWD = 32'hDEADBEEF; iISSUE = 1; iISSUE_RD = 0;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd0, 5'd0};
    tick();
    tests++;
    if (oRD !== '0 || oBUSY !== '0) begin
      fails++; $display("FAIL x0_read rd=%h busy=%b exp 0/0", oRD, oBUSY);
    end
  endtask

  task automatic test_write_read();
    idle(); iWE = 1; iWA = 7; iWD = 32'h12345678;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd7, 5'd7}; iWE = 1; iWA = 8; iWD = 32'hCAFE0008;
    tick();
    tests++;
    if (oRD !== {32'h12345678, 32'h12345678}) begin
      fails++; $display("FAIL write_read rd=%h exp 1234567812345678", oRD);
    end
    idle(); iRE = 2'b01; iRA = {5'd0, 5'd8};
    tick();
    tests++;
    if (oRD[31:0] !== 32'hCAFE0008) begin
      fails++; $display("FAIL concurrent_write rd0=%h exp cafe0008", oRD[31:0]);
    end
  endtask

  task automatic test_collision();
    idle(); iWE = 1; iWA = 3; iWD = 32'h11; iISSUE = 1; iISSUE_RD = 3;
    tick();
    idle(); iWE = 1; iWA = 3; iWD = 32'h22; iRE = 2'b11; iRA = {5'd3, 5'd3};
    tick();
    tests++;
    if (oRD !== {COL_RD, COL_RD} || oBUSY !== COL_BUSY) begin
      fails++; $display("FAIL collision rd=%h busy=%b exp %h/%b", oRD, oBUSY, {COL_RD, COL_RD}, COL_BUSY);
    end
    idle(); iRE = 2'b11; iRA = {5'd3, 5'd3};
    tick();
    tests++;
    if (oRD !== {32'h22, 32'h22} || oBUSY !== 2'b00) begin
      fails++; $display("FAIL collision_after rd=%h busy=%b exp 0000002200000022/00", oRD, oBUSY);
    end
  endtask

  task automatic test_scoreboard();
    idle(); iISSUE = 1; iISSUE_RD = 10;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd10, 5'd10};
    tick();
    tests++;
    if (oBUSY !== 2'b11) begin
      fails++; $display("FAIL sb_issue busy=%b exp 11", oBUSY);
    end
    idle(); iWE = 1; iWA = 10; iWD = 32'hA0;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd10, 5'd10};
    tick();
    tests++;
    if (oBUSY !== 2'b00 || oRD[31:0] !== 32'hA0) begin
      fails++; $display("FAIL sb_write_clear busy=%b rd0=%h exp 00/000000a0", oBUSY, oRD[31:0]);
    end
    idle(); iISSUE = 1; iISSUE_RD = 12; iWE = 1; iWA = 12; iWD = 32'hC;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd10, 5'd12};
    tick();
    tests++;
    if (oBUSY !== 2'b01) begin
      fails++; $display("FAIL sb_issue_wins busy=%b exp 01", oBUSY);
    end
    // A second issue to a pending register does not count: one write clears it.
    idle(); iISSUE = 1; iISSUE_RD = 12;
    tick();
    idle(); iWE = 1; iWA = 12; iWD = 32'hD;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd12, 5'd12};
    tick();
    tests++;
    if (oBUSY !== 2'b00) begin
      fails++; $display("FAIL sb_no_count busy=%b exp 00", oBUSY);
    end
    idle(); iISSUE = 1; iISSUE_RD = 13; iRE = 2'b11; iRA = {5'd13, 5'd13};
    tick();
    tests++;
    if (oBUSY !== 2'b00) begin
      fails++; $display("FAIL sb_read_issue_same busy=%b exp 00", oBUSY);
    end
    idle(); iRE = 2'b11; iRA = {5'd13, 5'd13};
    tick();
    tests++;
    if (oBUSY !== 2'b11) begin
      fails++; $display("FAIL sb_read_issue_next busy=%b exp 11", oBUSY);
    end
  endtask

  task automatic test_read_hold();
    idle(); iWE = 1; iWA = 4; iWD = 32'hAA;
    tick();
    idle(); iRE = 2'b11; iRA = {5'd4, 5'd4};
    tick();
    tests++;
    if (oRD !== {32'hAA, 32'hAA}) begin
      fails++; $display("FAIL hold_load rd=%h exp 000000aa000000aa", oRD);
    end
    idle(); iRA = {5'd4, 5'd4}; iWE = 1; iWA = 4; iWD = 32'hBB;
    tick();
    idle(); iRA = {5'd4, 5'd4};
    tick();
    tests++;
    if (oRD !== {32'hAA, 32'hAA}) begin
      fails++; $display("FAIL hold_disabled rd=%h exp 000000aa000000aa", oRD);
    end
    iRE = 2'b01;
    tick();
    tests++;
    if (oRD !== {32'hAA, 32'hBB}) begin
      fails++; $display("FAIL hold_port_indep rd=%h exp 000000aa000000bb", oRD);
    end
  endtask

  initial begin
    iRST = 1;
    iRA = '0;
    idle();
    tick();
    tick();
    iRST = 0;
    test_reset();
    test_x0();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_read_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the RV32 core; successor to the single-write/two-read register block.
- Adds configurable read-port count, registered reads that are independent of writes, a hardwired-zero register 0, async clear of all state, and a per-register pending-write scoreboard for decode-stage hazard checks.
- Sits between decode (read/issue) and writeback (write).

Parameters:
ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH.
DATA_WIDTH, 32, register word width.
NUM_READ, 2, number of read ports (1..4).

Ports:
iCLK  input  1  clock, all state updates on posedge.
iRST  input  1  asynchronous active-high reset.
iWE  input  1  write enable (writeback).
iWA  input  ADDRESS_WIDTH  write address.
iWD  input  DATA_WIDTH  write data.
iRE  input  NUM_READ  per-port read enable.
iRA  input  NUM_READ*ADDRESS_WIDTH  read addresses; port p at bits [p*AW +: AW].
oRD  output  NUM_READ*DATA_WIDTH  registered read data; port p at [p*DW +: DW].
oBUSY  output  NUM_READ  registered pending-write flag for the register read on port p.
iISSUE  input  1  instruction with destination issued; marks destination pending.
iISSUE_RD  input  ADDRESS_WIDTH  destination of issued instruction.

Behaviour:
- Clock and reset: one clock iCLK; reset iRST is asynchronous and active-high.
- Reset (async assert, sync-safe deassert by the system):
  - all registers = 0;
  - all pending bits = 0;
  - oRD = 0, oBUSY = 0.
  - Reset mid-write discards the write. Reset mid-issue discards the issue.
- Register 0:
  - writes to address 0 are ignored;
  - reads of address 0 return 0;
  - issue to address 0 never sets pending; oBUSY is always 0 for address 0.
- Write: on posedge with iWE=1 and iWA!=0, reg[iWA] <= iWD. Writes never block reads; reads and a write occur in the same cycle.
- Read: 1-cycle latency.
  - On posedge with iRE[p]=1, oRD[p] <= value of reg[iRA[p]]; oBUSY[p] <= pending[iRA[p]].
  - iRE[p]=0: oRD[p] and oBUSY[p] hold.
  - Ports are fully independent. Any ports may read the same address.
- Scoreboard:
  - iISSUE=1 and iISSUE_RD!=0 sets pending[iISSUE_RD].
  - iWE=1 and iWA!=0 clears pending[iWA].
  - Same-cycle issue and write to the same register: pending ends set (the newer instruction wins).
  - Issue to an already pending register: stays set (no counting).
  - Write to a non-pending register: allowed; pending stays 0.
- Same-cycle read/write collision, same address: see Optional Feature.
- Same-cycle read/issue collision, same address: oBUSY reflects pending before the issue (the issuing instruction does not see its own hazard).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first):
  - a read on port p whose iRA[p] equals iWA with iWE=1 and iWA!=0 returns iWD;
  - oBUSY[p] returns 0 unless the register is also issued in that same cycle, in which case it returns the pre-issue pending value with the write applied, i.e. 0.
- Undefined (read-first):
  - the same read returns the old register value;
  - oBUSY[p] returns the old pending bit.
- All other behaviour is identical in both builds.

Decomposition:
- Package regfile_pkg:
  - ZERO_REG index constant;
  - default width/depth constants;
  - typedef reg_addr_t (logic [ADDRESS_WIDTH-1:0]);
  - typedef reg_data_t (logic [DATA_WIDTH-1:0]).
- Sub-module regfile_scoreboard:
  - owns the pending bit vector, issue/write set-clear priority and x0 masking;
  - exposes the pending vector to the top-level read logic.
- Storage, read registers and bypass muxing stay in regfile_mp using a generate loop over NUM_READ.

Test Plan:
- Reset then read: assert iRST mid-cycle, read addr 5 and 31 on both ports -> oRD=0 and oBUSY=0 immediately after reset assertion and on the next read.
- x0 protection: write 0xDEADBEEF to addr 0, issue to addr 0, read addr 0 -> oRD=0, oBUSY=0.
- Write then read: write 0x12345678 to addr 7; the next cycle, read addr 7 on port 0 and addr 7 on port 1 -> both 0x12345678 one cycle later, while a concurrent write to addr 8 still lands.
- Collision: reg 3 = 0x11, same cycle write 0x22 to addr 3 and read addr 3 -> 0x22 with REGFILE_BYPASS_EN, 0x11 without; next read -> 0x22 in both builds.
- Scoreboard:
  - issue rd=10; next cycle read 10 -> oBUSY=1;
  - write 10 -> the next read gives oBUSY=0;
  - issue 12 and write 12 in the same cycle -> a later read gives oBUSY=1.
- Read enable hold: read addr 4 = 0xAA, then set iRE=0 and write addr 4 = 0xBB -> oRD holds 0xAA until iRE=1.
